gray_counter: RTL

Parametrised up/down counter whose registered output is presented either as plain binary or as reflected Gray code, selectable every cycle. It generalises the fixed 3-bit binary-to-Gray mapping to any width and adds counting, loading and wrap detection. It can accept a load value in either binary or Gray form. It sits in the datapath exercises as the stepping source for Gray-coded pointers and position encoders.

---
 rtl/gray_counter.sv | 59 +++++
 1 files changed

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with registered binary or Gray output
// Ports:
//    clk        rising-edge clock
//    reset      asynchronous active-high reset
//    en         count enable (ignored while load is high)
//    up         direction, 1 = increment, 0 = decrement
//    load       synchronous load, priority over en
//    load_gray  load_val is Gray-coded when high
//    load_val   value to load
//    select     output format, 1 = Gray, 0 = binary
//    out        registered count in the selected format
//    wrap       one-cycle pulse when a count step crossed the wrap boundary
module gray_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic             load_gray,
   input  logic [WIDTH-1:0] load_val,
   input  logic             select,
   output logic [WIDTH-1:0] out,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
   logic [WIDTH-1:0] cnt_q, cnt_d, out_q, out_d;
   logic             wrap_q, wrap_d;
   always_comb begin
      cnt_d  = load ? (load_gray ? gray2bin(load_val) : load_val)
             : en ? (up ? cnt_q + ONE : cnt_q - ONE) : cnt_q;
      // loads never report a wrap, even when they jump across the boundary
      wrap_d = !load && en && (up ? &cnt_q : ~|cnt_q);
      out_d  = select ? bin2gray(cnt_d) : cnt_d;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         out_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         wrap_q <= wrap_d;
      end
   end
   assign out  = out_q;
   assign wrap = wrap_q;
endmodule
